// File: rtl/doa_pkg.sv
// doa_pkg: shared types and default widths for the DOA frame sequencer.
//   state_t  : sequencer FSM states
//   status_t : result status codes carried on res_status
//   owner_t  : which agent currently drives the FFT_RAM read ports
//   result_t : one published result {bnum, doa, frame, status}
package doa_pkg;

   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_BNUM_W  = 6;
   localparam int DEF_DOA_W   = 8;
   localparam int DEF_FRAME_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      WAIT_WB = 2'd2,
      PUBLISH = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_TIMEOUT = 2'd1,
      ST_BADBIN  = 2'd2
   } status_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_WB   = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

   typedef struct packed {
      logic [DEF_BNUM_W-1:0]  bnum;
      logic [DEF_DOA_W-1:0]   doa;
      logic [DEF_FRAME_W-1:0] frame;
      status_t                status;
   } result_t;

endpackage

// File: rtl/ram_read_mux.sv
// ram_read_mux: steers the four FFT_RAM read-address ports to their owner.
//   owner               : OWN_WB, OWN_HOST or OWN_NONE
//   wb_addr1..wb_addr4  : weightblock-side addresses (port 1 is the peak bin)
//   host_addr           : host readback address, fanned out to all four ports
//   ram_rdaddr1..4      : addresses driven to the RAMs (0 when nobody owns them)
module ram_read_mux
   import doa_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  owner_t            owner,
   input  logic [ADDR_W-1:0] wb_addr1,
   input  logic [ADDR_W-1:0] wb_addr2,
   input  logic [ADDR_W-1:0] wb_addr3,
   input  logic [ADDR_W-1:0] wb_addr4,
   input  logic [ADDR_W-1:0] host_addr,
   output logic [ADDR_W-1:0] ram_rdaddr1,
   output logic [ADDR_W-1:0] ram_rdaddr2,
   output logic [ADDR_W-1:0] ram_rdaddr3,
   output logic [ADDR_W-1:0] ram_rdaddr4
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned; an unassigned path would infer a latch.
      ram_rdaddr1 = '0;
      ram_rdaddr2 = '0;
      ram_rdaddr3 = '0;
      ram_rdaddr4 = '0;
      unique case (owner)
         OWN_WB: begin
            ram_rdaddr1 = wb_addr1;
            ram_rdaddr2 = wb_addr2;
            ram_rdaddr3 = wb_addr3;
            ram_rdaddr4 = wb_addr4;
         end
         OWN_HOST: begin
            ram_rdaddr1 = host_addr;
            ram_rdaddr2 = host_addr;
            ram_rdaddr3 = host_addr;
            ram_rdaddr4 = host_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/doa_sequencer.sv
// doa_sequencer: frame-level controller for the beamforming DOA datapath.
//   fft_valid/maxbin_in       : new FFT frame and its peak bin
//   fft_lock                  : holds off the FFT writer while a frame is consumed
//   wb_detectdone/wb_maxbin   : weightblock start pulse and the bin it works on
//   wb_reset                  : reset | one-cycle abort after a watchdog timeout
//   wb_rdaddr2..4, wb_done, wb_bnum, wb_doa : weightblock side
//   host_req/host_addr/host_gnt : host readback arbitration
//   ram_rdaddr1..4            : muxed FFT_RAM read addresses
//   res_*                     : registered result, valid/ready handshake
//   overrun_cnt               : saturating count of dropped frames
module doa_sequencer
   import doa_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int BNUM_W  = DEF_BNUM_W,
   parameter int DOA_W   = DEF_DOA_W,
   parameter int FRAME_W = DEF_FRAME_W,
   parameter int MIN_BIN = 1,
   parameter int MAX_BIN = 511,
   parameter int TIMEOUT = 4095
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fft_valid,
   input  logic [ADDR_W-1:0]  maxbin_in,
   output logic               fft_lock,
   output logic               wb_detectdone,
   output logic [ADDR_W-1:0]  wb_maxbin,
   output logic               wb_reset,
   input  logic [ADDR_W-1:0]  wb_rdaddr2,
   input  logic [ADDR_W-1:0]  wb_rdaddr3,
   input  logic [ADDR_W-1:0]  wb_rdaddr4,
   input  logic               wb_done,
   input  logic [BNUM_W-1:0]  wb_bnum,
   input  logic [DOA_W-1:0]   wb_doa,
   input  logic               host_req,
   input  logic [ADDR_W-1:0]  host_addr,
   output logic               host_gnt,
   output logic [ADDR_W-1:0]  ram_rdaddr1,
   output logic [ADDR_W-1:0]  ram_rdaddr2,
   output logic [ADDR_W-1:0]  ram_rdaddr3,
   output logic [ADDR_W-1:0]  ram_rdaddr4,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [BNUM_W-1:0]  res_bnum,
   output logic [DOA_W-1:0]   res_doa,
   output logic [FRAME_W-1:0] res_frame,
   output logic [1:0]         res_status,
   output logic [7:0]         overrun_cnt
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t             state_q, state_d;
   logic [FRAME_W-1:0] frame_cnt_q;
   logic               pend_q;
   logic [ADDR_W-1:0]  pend_bin_q;
   logic [FRAME_W-1:0] pend_frame_q;
   logic [ADDR_W-1:0]  cur_bin_q;
   logic [FRAME_W-1:0] cur_frame_q;
   logic [WD_W-1:0]    wd_q;
   result_t            res_q;
   logic               res_valid_q;
   logic               host_gnt_q;
   logic               abort_q;
   logic [7:0]         overrun_q;

   logic               take_new, take_pend, take_any, to_pend, drop;
   logic [ADDR_W-1:0]  sel_bin;
   logic [FRAME_W-1:0] sel_frame;
   logic               bin_ok, done_hit, timeout_hit, xfer;
   owner_t             owner;

   always_comb begin
      // A parked frame has priority over a new one; a new frame arriving in
      // the same cycle the parked one launches is an overrun.
      take_pend   = (state_q == IDLE) && pend_q && !host_gnt_q;
      take_new    = (state_q == IDLE) && fft_valid && !pend_q && !host_gnt_q;
      to_pend     = (state_q == IDLE) && fft_valid && !pend_q && host_gnt_q;
      take_any    = take_pend || take_new;
      drop        = fft_valid && !take_new && !to_pend;
      sel_bin     = take_pend ? pend_bin_q : maxbin_in;
      sel_frame   = take_pend ? pend_frame_q : frame_cnt_q;
      bin_ok      = (sel_bin >= ADDR_W'(MIN_BIN)) && (sel_bin <= ADDR_W'(MAX_BIN));
      done_hit    = (state_q == WAIT_WB) && wb_done;
      // Done wins over a coincident timeout.
      timeout_hit = (state_q == WAIT_WB) && !wb_done && (wd_q == WD_W'(TIMEOUT - 1));
      xfer        = (state_q == PUBLISH) && res_valid_q && res_ready;

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (take_any) state_d = bin_ok ? LAUNCH : PUBLISH;
         LAUNCH:  state_d = WAIT_WB;
         WAIT_WB: if (done_hit || timeout_hit) state_d = PUBLISH;
         PUBLISH: if (xfer) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      owner = OWN_NONE;
      if (state_q == LAUNCH || state_q == WAIT_WB) owner = OWN_WB;
      else if (host_gnt_q)                          owner = OWN_HOST;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         frame_cnt_q  <= '0;
         pend_q       <= 1'b0;
         pend_bin_q   <= '0;
         pend_frame_q <= '0;
         cur_bin_q    <= '0;
         cur_frame_q  <= '0;
         wd_q         <= '0;
         res_q        <= '0;
         res_valid_q  <= 1'b0;
         host_gnt_q   <= 1'b0;
         abort_q      <= 1'b0;
         overrun_q    <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         state_q <= state_d;

         // Every arriving frame consumes an id, including dropped ones.
         if (fft_valid) frame_cnt_q <= frame_cnt_q + FRAME_W'(1);

         if (to_pend) begin
            pend_q       <= 1'b1;
            pend_bin_q   <= maxbin_in;
            pend_frame_q <= frame_cnt_q;
         end else if (take_pend) begin
            pend_q <= 1'b0;
         end

         if (drop && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;

         if (take_any) begin
            cur_frame_q <= sel_frame;
            if (bin_ok) cur_bin_q <= sel_bin;
            else        res_q <= '{bnum: '0, doa: '0, frame: sel_frame, status: ST_BADBIN};
         end

         if (done_hit)
            res_q <= '{bnum: wb_bnum, doa: wb_doa, frame: cur_frame_q, status: ST_OK};
         else if (timeout_hit)
            res_q <= '{bnum: '0, doa: '0, frame: cur_frame_q, status: ST_TIMEOUT};

         if (state_q == LAUNCH)       wd_q <= '0;
         else if (state_q == WAIT_WB) wd_q <= wd_q + WD_W'(1);

         abort_q <= timeout_hit;

         // Registered valid: rises one cycle after entering PUBLISH.
         res_valid_q <= (state_q == PUBLISH) && !xfer;

         // Grant only from a quiet IDLE; once held, it follows host_req.
         if (host_gnt_q) host_gnt_q <= host_req;
         else            host_gnt_q <= host_req && (state_q == IDLE) && !pend_q && !fft_valid;
      end
   end

   assign fft_lock      = (state_q != IDLE);
   assign wb_detectdone = (state_q == LAUNCH);
   assign wb_maxbin     = cur_bin_q;
   assign wb_reset      = reset | abort_q;
   assign host_gnt      = host_gnt_q;
   assign res_valid     = res_valid_q;
   assign res_bnum      = res_q.bnum;
   assign res_doa       = res_q.doa;
   assign res_frame     = res_q.frame;
   assign res_status    = res_q.status;
   assign overrun_cnt   = overrun_q;

   ram_read_mux #(.ADDR_W(ADDR_W)) u_ram_read_mux (
      .owner       (owner),
      .wb_addr1    (cur_bin_q),
      .wb_addr2    (wb_rdaddr2),
      .wb_addr3    (wb_rdaddr3),
      .wb_addr4    (wb_rdaddr4),
      .host_addr   (host_addr),
      .ram_rdaddr1 (ram_rdaddr1),
      .ram_rdaddr2 (ram_rdaddr2),
      .ram_rdaddr3 (ram_rdaddr3),
      .ram_rdaddr4 (ram_rdaddr4)
   );

endmodule

// File: tb/tb_doa_sequencer.sv
`timescale 1ns/1ps
module tb_doa_sequencer;
   import doa_pkg::*;

   localparam int ADDR_W  = 10;
   localparam int BNUM_W  = 6;
   localparam int DOA_W   = 8;
   localparam int FRAME_W = 8;
   localparam int TIMEOUT = 4095;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic               fft_valid;
   logic [ADDR_W-1:0]  maxbin_in;
   logic               fft_lock;
   logic               wb_detectdone;
   logic [ADDR_W-1:0]  wb_maxbin;
   logic               wb_reset;
   logic [ADDR_W-1:0]  wb_rdaddr2, wb_rdaddr3, wb_rdaddr4;
   logic               wb_done;
   logic [BNUM_W-1:0]  wb_bnum;
   logic [DOA_W-1:0]   wb_doa;
   logic               host_req;
   logic [ADDR_W-1:0]  host_addr;
   logic               host_gnt;
   logic [ADDR_W-1:0]  ram_rdaddr1, ram_rdaddr2, ram_rdaddr3, ram_rdaddr4;
   logic               res_valid;
   logic               res_ready;
   logic [BNUM_W-1:0]  res_bnum;
   logic [DOA_W-1:0]   res_doa;
   logic [FRAME_W-1:0] res_frame;
   logic [1:0]         res_status;
   logic [7:0]         overrun_cnt;

   doa_sequencer #(
      .ADDR_W(ADDR_W), .BNUM_W(BNUM_W), .DOA_W(DOA_W), .FRAME_W(FRAME_W),
      .MIN_BIN(1), .MAX_BIN(511), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .fft_valid(fft_valid), .maxbin_in(maxbin_in),
      .fft_lock(fft_lock), .wb_detectdone(wb_detectdone), .wb_maxbin(wb_maxbin),
      .wb_reset(wb_reset), .wb_rdaddr2(wb_rdaddr2), .wb_rdaddr3(wb_rdaddr3),
      .wb_rdaddr4(wb_rdaddr4), .wb_done(wb_done), .wb_bnum(wb_bnum), .wb_doa(wb_doa),
      .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
      .ram_rdaddr1(ram_rdaddr1), .ram_rdaddr2(ram_rdaddr2),
      .ram_rdaddr3(ram_rdaddr3), .ram_rdaddr4(ram_rdaddr4),
      .res_valid(res_valid), .res_ready(res_ready), .res_bnum(res_bnum),
      .res_doa(res_doa), .res_frame(res_frame), .res_status(res_status),
      .overrun_cnt(overrun_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard of expected results, pushed when a frame is sent.
   result_t sb[$];
   int      exp_n = 0;

   task automatic push_exp(input int bnum, input int doa, input int frame, input status_t st);
      result_t r;
      r.bnum   = BNUM_W'(bnum);
      r.doa    = DOA_W'(doa);
      r.frame  = FRAME_W'(frame);
      r.status = st;
      sb.push_back(r);
      exp_n++;
   endtask

   // Weightblock stub: wb_done stub_lat cycles after the start pulse (0 = never).
   int               stub_lat = 30;
   logic [BNUM_W-1:0] stub_bnum = '0;
   logic [DOA_W-1:0]  stub_doa  = '0;

   initial begin
      int lat;
      wb_done = 1'b0;
      wb_bnum = '0;
      wb_doa  = '0;
      forever begin
         @(posedge clk); #1;
         if (wb_detectdone === 1'b1 && stub_lat > 0) begin
            lat = stub_lat;
            repeat (lat) @(posedge clk);
            #1;
            wb_done = 1'b1;
            wb_bnum = stub_bnum;
            wb_doa  = stub_doa;
            @(posedge clk); #1;
            wb_done = 1'b0;
         end
      end
   end

   // Monitor: event counters, cycle stamps, read-port checks, result pops.
   int              cyc = 0;
   int              n_launch = 0, n_abort = 0, n_results = 0;
   int              launch_cyc = 0, abort_cyc = 0, valid_cyc = 0, gnt_fall_cyc = 0;
   int              rd1_bad = 0, gnt_lock_bad = 0;
   logic            wb_busy = 1'b0, prev_gnt = 1'b0, prev_valid = 1'b0;
   logic [ADDR_W-1:0] exp_rd1 = '0;

   always @(negedge clk) begin
      result_t e;
      logic    busy_now;
      cyc <= cyc + 1;
      busy_now = wb_busy;
      if (reset) begin
         busy_now = 1'b0;
      end else begin
         if (wb_reset) begin
            n_abort   <= n_abort + 1;
            abort_cyc <= cyc;
            busy_now  = 1'b0;
         end
         if (wb_detectdone) begin
            n_launch   <= n_launch + 1;
            launch_cyc <= cyc;
            busy_now   = 1'b1;
         end
         if (busy_now && ram_rdaddr1 !== exp_rd1) rd1_bad <= rd1_bad + 1;
         if (wb_done) busy_now = 1'b0;
         if (host_gnt && fft_lock) gnt_lock_bad <= gnt_lock_bad + 1;
         if (prev_gnt && !host_gnt) gnt_fall_cyc <= cyc;
         if (!prev_valid && res_valid) valid_cyc <= cyc;
         if (res_valid && res_ready) begin
            n_results <= n_results + 1;
            if (sb.size() == 0) begin
               check("sb_unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               check("res_bnum",   int'(res_bnum),   int'(e.bnum));
               check("res_doa",    int'(res_doa),    int'(e.doa));
               check("res_frame",  int'(res_frame),  int'(e.frame));
               check("res_status", int'(res_status), int'(e.status));
            end
         end
      end
      wb_busy    <= busy_now;
      prev_gnt   <= host_gnt;
      prev_valid <= res_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int bin);
      fft_valid = 1'b1;
      maxbin_in = ADDR_W'(bin);
      tick(1);
      fft_valid = 1'b0;
   endtask

   task automatic wait_results(input int budget);
      int k = 0;
      while (n_results < exp_n && k < budget) begin
         tick(1);
         k++;
      end
      check("result_arrived", int'(n_results >= exp_n), 1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic set_stub(input int bnum, input int doa, input int lat);
      stub_bnum = BNUM_W'(bnum);
      stub_doa  = DOA_W'(doa);
      stub_lat  = lat;
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int k, d, snap, hold_bad;
      reset      = 1'b1;
      fft_valid  = 1'b0;
      maxbin_in  = '0;
      host_req   = 1'b0;
      host_addr  = ADDR_W'(55);
      res_ready  = 1'b1;
      wb_rdaddr2 = ADDR_W'(201);
      wb_rdaddr3 = ADDR_W'(202);
      wb_rdaddr4 = ADDR_W'(203);
      tick(3);

      // Reset values
      check("rst_fft_lock",   int'(fft_lock), 0);
      check("rst_detectdone", int'(wb_detectdone), 0);
      check("rst_wb_reset",   int'(wb_reset), 1);
      check("rst_host_gnt",   int'(host_gnt), 0);
      check("rst_res_valid",  int'(res_valid), 0);
      check("rst_overrun",    int'(overrun_cnt), 0);
      check("rst_rdaddr1",    int'(ram_rdaddr1), 0);
      check("rst_wb_maxbin",  int'(wb_maxbin), 0);
      reset = 1'b0;
      host_addr = '0;
      tick(1);
      check("post_rst_wb_reset", int'(wb_reset), 0);

      // Bring-up
      set_stub(7, 75, 30);
      exp_rd1 = ADDR_W'(44);
      push_exp(7, 75, 0, ST_OK);
      send_frame(44);
      tick(10);
      check("bu_fft_lock_mid", int'(fft_lock), 1);
      check("bu_rdaddr2", int'(ram_rdaddr2), 201);
      check("bu_rdaddr3", int'(ram_rdaddr3), 202);
      check("bu_rdaddr4", int'(ram_rdaddr4), 203);
      wait_results(200);
      check("bu_launches", n_launch, 1);
      check("bu_latency", valid_cyc - launch_cyc, 32);
      check("bu_rd1_stable", rd1_bad, 0);
      tick(1);
      check("bu_lock_released", int'(fft_lock), 0);
      check("bu_valid_dropped", int'(res_valid), 0);

      // Backpressure
      apply_reset();
      res_ready = 1'b0;
      set_stub(3, 30, 10);
      exp_rd1 = ADDR_W'(60);
      push_exp(3, 30, 0, ST_OK);
      send_frame(60);
      k = 0;
      while (!res_valid && k < 100) begin tick(1); k++; end
      check("bp_valid_seen", int'(res_valid), 1);
      hold_bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) begin fft_valid = 1'b1; maxbin_in = ADDR_W'(70); end
         if (i == 21) fft_valid = 1'b0;
         if (!res_valid || !fft_lock || res_bnum !== 6'd3 || res_doa !== 8'd30 ||
             res_frame !== 8'd0 || res_status !== 2'd0) hold_bad++;
         tick(1);
      end
      check("bp_hold_stable", hold_bad, 0);
      check("bp_overrun", int'(overrun_cnt), 1);
      res_ready = 1'b1;
      wait_results(10);
      set_stub(4, 40, 8);
      exp_rd1 = ADDR_W'(61);
      push_exp(4, 40, 2, ST_OK);
      send_frame(61);
      wait_results(100);

      // Host share
      apply_reset();
      host_req  = 1'b1;
      host_addr = ADDR_W'(100);
      tick(2);
      check("hs_gnt", int'(host_gnt), 1);
      check("hs_rd1", int'(ram_rdaddr1), 100);
      check("hs_rd2", int'(ram_rdaddr2), 100);
      check("hs_rd3", int'(ram_rdaddr3), 100);
      check("hs_rd4", int'(ram_rdaddr4), 100);
      snap = n_launch;
      set_stub(5, 50, 8);
      exp_rd1 = ADDR_W'(80);
      push_exp(5, 50, 0, ST_OK);
      send_frame(80);
      tick(5);
      check("hs_pending_no_launch", n_launch - snap, 0);
      check("hs_gnt_held", int'(host_gnt), 1);
      check("hs_lock_low", int'(fft_lock), 0);
      host_req = 1'b0;
      wait_results(100);
      check("hs_launch_after_drop", launch_cyc - gnt_fall_cyc, 1);
      check("hs_rd1_wb", rd1_bad, 0);
      // Simultaneous frame and host request: frame wins
      set_stub(6, 60, 8);
      exp_rd1 = ADDR_W'(90);
      push_exp(6, 60, 1, ST_OK);
      host_req = 1'b1;
      send_frame(90);
      check("hs_sim_no_gnt", int'(host_gnt), 0);
      wait_results(100);
      tick(2);
      check("hs_gnt_after_publish", int'(host_gnt), 1);
      check("hs_gnt_never_with_lock", gnt_lock_bad, 0);
      host_req = 1'b0;
      tick(2);

      // Timeout
      apply_reset();
      set_stub(0, 0, 0);
      exp_rd1 = ADDR_W'(123);
      snap = n_abort;
      push_exp(0, 0, 0, ST_TIMEOUT);
      send_frame(123);
      wait_results(TIMEOUT + 200);
      check("to_one_abort", n_abort - snap, 1);
      d = abort_cyc - launch_cyc;
      check("to_abort_timing", int'(d >= TIMEOUT && d <= TIMEOUT + 2), 1);
      set_stub(9, 99, 5);
      exp_rd1 = ADDR_W'(200);
      push_exp(9, 99, 1, ST_OK);
      send_frame(200);
      wait_results(100);
      check("to_rd1_wb", rd1_bad, 0);

      // Bin rejection and range boundaries
      apply_reset();
      snap = n_launch;
      push_exp(0, 0, 0, ST_BADBIN);
      send_frame(0);
      wait_results(50);
      push_exp(0, 0, 1, ST_BADBIN);
      send_frame(600);
      wait_results(50);
      check("br_no_launch", n_launch - snap, 0);
      set_stub(2, 22, 4);
      exp_rd1 = ADDR_W'(511);
      push_exp(2, 22, 2, ST_OK);
      send_frame(511);
      wait_results(50);
      set_stub(3, 33, 4);
      exp_rd1 = ADDR_W'(1);
      push_exp(3, 33, 3, ST_OK);
      send_frame(1);
      wait_results(50);
      check("br_boundary_launches", n_launch - snap, 2);

      // Reset in the middle of WAIT_WB
      apply_reset();
      set_stub(8, 88, 30);
      exp_rd1 = ADDR_W'(44);
      send_frame(44);
      tick(10);
      send_frame(45);
      check("mr_overrun_before", int'(overrun_cnt), 1);
      reset = 1'b1;
      tick(1);
      check("mr_fft_lock",   int'(fft_lock), 0);
      check("mr_wb_reset",   int'(wb_reset), 1);
      check("mr_res_valid",  int'(res_valid), 0);
      check("mr_overrun",    int'(overrun_cnt), 0);
      check("mr_wb_maxbin",  int'(wb_maxbin), 0);
      check("mr_res_bnum",   int'(res_bnum), 0);
      reset = 1'b0;
      snap = n_results;
      tick(40);
      check("mr_late_done_ignored", n_results - snap, 0);
      check("mr_idle_after_late_done", int'(fft_lock), 0);
      set_stub(1, 2, 6);
      exp_rd1 = ADDR_W'(50);
      push_exp(1, 2, 0, ST_OK);
      send_frame(50);
      wait_results(100);

      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
